// File: rtl/vga_ctrl.sv
// VGA timing generator with a streaming pixel input and registered, mutually aligned outputs.
// Optional build macro VGA_TEST_PATTERN_EN replaces the pixel stream with eight colour bars.
module vga_ctrl #(
  parameter int HDISP  = 640,
  parameter int HFP    = 16,
  parameter int HPULSE = 96,
  parameter int HBP    = 48,
  parameter int VDISP  = 480,
  parameter int VFP    = 10,
  parameter int VPULSE = 2,
  parameter int VBP    = 33
) (
  input  logic                       CLK,
  input  logic                       NRST,
  input  logic [23:0]                pix_data,
  input  logic                       pix_valid,
  output logic                       pix_ready,
  output logic [7:0]                 vga_r,
  output logic [7:0]                 vga_g,
  output logic [7:0]                 vga_b,
  output logic                       vga_hs,
  output logic                       vga_vs,
  output logic                       vga_blank,
  output logic [$clog2(HDISP)-1:0]   vga_x,
  output logic [$clog2(VDISP)-1:0]   vga_y,
  output logic                       frame_start,
  output logic                       underflow
);
  localparam int HTOTAL = HDISP + HFP + HPULSE + HBP;
  localparam int VTOTAL = VDISP + VFP + VPULSE + VBP;
  localparam int HW = $clog2(HTOTAL);
  localparam int VW = $clog2(VTOTAL);
  localparam int XW = $clog2(HDISP);
  localparam int YW = $clog2(VDISP);

  if (HFP < 1 || HPULSE < 1 || HBP < 1 || VFP < 1 || VPULSE < 1 || VBP < 1) begin : g_param_check
    $error("vga_ctrl: porch and pulse parameters must each be at least 1");
  end

  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic [23:0]   rgb_q, rgb_d;
  logic          hs_q, hs_d, vs_q, vs_d, blank_q, blank_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          fs_q, fs_d, uf_q, uf_d;
  logic          active;

  assign active = (hcnt_q < HW'(HDISP)) && (vcnt_q < VW'(VDISP));

  always_comb begin
    hcnt_d = hcnt_q + 1'b1;
    vcnt_d = vcnt_q;
    if (hcnt_q == HW'(HTOTAL - 1)) begin
      hcnt_d = '0;
      vcnt_d = (vcnt_q == VW'(VTOTAL - 1)) ? '0 : vcnt_q + 1'b1;
    end
  end

  // Everything below is a function of the current counters, registered once for alignment.
  always_comb begin
    hs_d    = !((hcnt_q >= HW'(HDISP + HFP)) && (hcnt_q < HW'(HDISP + HFP + HPULSE)));
    vs_d    = !((vcnt_q >= VW'(VDISP + VFP)) && (vcnt_q < VW'(VDISP + VFP + VPULSE)));
    blank_d = active;
    x_d     = active ? XW'(hcnt_q) : '0;
    y_d     = active ? YW'(vcnt_q) : '0;
    fs_d    = (hcnt_q == '0) && (vcnt_q == '0);
  end

`ifdef VGA_TEST_PATTERN_EN
  localparam int BARW = (HDISP / 8 > 0) ? HDISP / 8 : 1;
  logic [HW-1:0] bar_raw;
  logic [2:0]    bar;
  logic          unused_tp;

  assign unused_tp = ^{pix_data, pix_valid};
  assign pix_ready = 1'b0;
  assign bar_raw   = hcnt_q / HW'(BARW);
  assign bar       = (bar_raw > HW'(7)) ? 3'd7 : 3'(bar_raw);

  // Bar order white..black: R off on bit1, G off on bit2, B off on bit0.
  always_comb begin
    rgb_d = active ? {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}} : 24'h0;
    uf_d  = 1'b0;
  end
`else
  assign pix_ready = active && NRST;

  // A missing pixel outranks the frame-start clear.
  always_comb begin
    rgb_d = (pix_ready && pix_valid) ? pix_data : 24'h0;
    uf_d  = uf_q;
    if (pix_ready && !pix_valid) uf_d = 1'b1;
    else if (fs_d)               uf_d = 1'b0;
  end
`endif

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      rgb_q   <= '0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      blank_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      fs_q    <= 1'b0;
      uf_q    <= 1'b0;
    end else begin
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      rgb_q   <= rgb_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      blank_q <= blank_d;
      x_q     <= x_d;
      y_q     <= y_d;
      fs_q    <= fs_d;
      uf_q    <= uf_d;
    end
  end

  assign {vga_r, vga_g, vga_b} = rgb_q;
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign vga_blank   = blank_q;
  assign vga_x       = x_q;
  assign vga_y       = y_q;
  assign frame_start = fs_q;
  assign underflow   = uf_q;
endmodule

// File: tb/tb_vga_ctrl.sv
// Randomized bench for vga_ctrl against a timing model derived from a free-running cycle index.
module tb_vga_ctrl;
  localparam int HD = 8, HF = 2, HP = 3, HB = 1;
  localparam int VD = 4, VF = 1, VP = 2, VB = 1;
  localparam int HT = HD + HF + HP + HB;
  localparam int VT = VD + VF + VP + VB;
  localparam int FRAME = HT * VT;

  logic        CLK = 1'b0, NRST = 1'b0;
  logic [23:0] pix_data = '0;
  logic        pix_valid = 1'b0;
  logic        pix_ready;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs, vga_blank;
  logic [2:0]  vga_x;
  logic [1:0]  vga_y;
  logic        frame_start, underflow;

  vga_ctrl #(.HDISP(HD), .HFP(HF), .HPULSE(HP), .HBP(HB),
             .VDISP(VD), .VFP(VF), .VPULSE(VP), .VBP(VB)) dut (
    .CLK(CLK), .NRST(NRST), .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank(vga_blank),
    .vga_x(vga_x), .vga_y(vga_y), .frame_start(frame_start), .underflow(underflow));

  always #5 CLK = ~CLK;

  int n_chk = 0, n_fail = 0;
  int t;                       // cycles since reset release == current counter position
  int last_fs, vs_lo, last_hfall, hs_run;
  logic prev_hs;
  logic [23:0] e_rgb;
  logic e_hs, e_vs, e_blank, e_fs, e_uf;
  logic [31:0] e_x, e_y;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, t);
    end
  endtask

  task automatic clear_tracking();
    t = 0; e_uf = 1'b0; last_fs = -1; vs_lo = 0; last_hfall = -1; hs_run = 0; prev_hs = 1'b1;
  endtask

  task automatic check_reset_outs();
    chk("rst_rgb",   32'({vga_r, vga_g, vga_b}), 32'h0);
    chk("rst_hs",    32'(vga_hs), 32'd1);
    chk("rst_vs",    32'(vga_vs), 32'd1);
    chk("rst_blank", 32'(vga_blank), 32'd0);
    chk("rst_x",     32'(vga_x), 32'd0);
    chk("rst_y",     32'(vga_y), 32'd0);
    chk("rst_fs",    32'(frame_start), 32'd0);
    chk("rst_uf",    32'(underflow), 32'd0);
    chk("rst_ready", 32'(pix_ready), 32'd0);
  endtask

  // Called #1 after a rising edge: drive, predict, clock, compare.
  task automatic step(input logic v, input logic [23:0] d);
    int h, ln;
    bit act;
`ifdef VGA_TEST_PATTERN_EN
    logic [23:0] bars [8];
    bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
`endif
    h  = t % HT;
    ln = (t / HT) % VT;
    act = (h < HD) && (ln < VD);
    pix_valid = v;
    pix_data  = d;
    #1;
`ifdef VGA_TEST_PATTERN_EN
    chk("pix_ready", 32'(pix_ready), 32'd0);
    e_rgb = act ? bars[h / (HD / 8)] : 24'h0;
    e_uf  = 1'b0;
`else
    chk("pix_ready", 32'(pix_ready), 32'(act));
    e_rgb = (act && v) ? d : 24'h0;
    if (act && !v)              e_uf = 1'b1;
    else if (h == 0 && ln == 0) e_uf = 1'b0;
`endif
    e_hs    = !(h >= HD + HF && h < HD + HF + HP);
    e_vs    = !(ln >= VD + VF && ln < VD + VF + VP);
    e_blank = act;
    e_x     = act ? 32'(h) : 32'd0;
    e_y     = act ? 32'(ln) : 32'd0;
    e_fs    = (h == 0 && ln == 0);
    @(posedge CLK); #1;
    chk("rgb",   32'({vga_r, vga_g, vga_b}), 32'(e_rgb));
    chk("hs",    32'(vga_hs), 32'(e_hs));
    chk("vs",    32'(vga_vs), 32'(e_vs));
    chk("blank", 32'(vga_blank), 32'(e_blank));
    chk("x",     32'(vga_x), e_x);
    chk("y",     32'(vga_y), e_y);
    chk("fs",    32'(frame_start), 32'(e_fs));
    chk("uf",    32'(underflow), 32'(e_uf));
    // Period/width checks measured on the outputs themselves.
    if (frame_start) begin
      if (last_fs >= 0) begin
        chk("fs_period", t - last_fs, FRAME);
        chk("vs_low_per_frame", vs_lo, VP * HT);
      end
      last_fs = t; vs_lo = 0;
    end
    if (!vga_vs) vs_lo++;
    if (!vga_hs && prev_hs) begin
      chk("hs_fall_phase", t % HT, HD + HF);
      if (last_hfall >= 0) chk("hs_period", t - last_hfall, HT);
      last_hfall = t; hs_run = 0;
    end
    if (!vga_hs) hs_run++;
    if (vga_hs && !prev_hs) chk("hs_width", hs_run, HP);
    prev_hs = vga_hs;
    t++;
  endtask

  task automatic rand_step();
    logic v;
    v = ($urandom_range(0, 9) != 0);
    if (t % FRAME == 0) v = 1'b0;  // miss on the frame-start pixel
    step(v, 24'($urandom));
  endtask

  initial begin
    clear_tracking();
    #12;
    check_reset_outs();
    @(posedge CLK); #1;
    NRST = 1'b1;
    for (int i = 0; i < 2 * FRAME; i++) rand_step();
    for (int i = 0; i < FRAME; i++) step(1'b1, 24'h123456);
    for (int i = 0; i < 2 * FRAME; i++) step(!(i == 20), 24'h123456);
    for (int i = 0; i < 3 * HT + 3; i++) rand_step();
    while (t % HT != 5) rand_step();
    NRST = 1'b0;
    #1;
    check_reset_outs();
    @(posedge CLK); #1;
    check_reset_outs();
    @(posedge CLK); #1;
    NRST = 1'b1;
    clear_tracking();
    for (int i = 0; i < 2 * FRAME; i++) rand_step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
